piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: the sending end of the team's serial shift link.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per
//  bit period, MSB-first or LSB-first, with a per-bit strobe and an end-of-word pulse.
//  Sits between a word-producing datapath and a serial-in/parallel-out receiver.
// PARAMETERS
//  WIDTH         8  word length in bits (>=2)
//  CLKS_PER_BIT  1  clk cycles each bit is held on serial_out (>=1)
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  reset       in   1      synchronous, active-high reset
//  data_in     in   WIDTH  word to transmit, sampled on accept
//  lsb_first   in   1      bit order, sampled on accept (0 = MSB first)
//  load_valid  in   1      producer has a word on data_in
//  load_ready  out  1      block can accept a word (combinational: state==IDLE)
//  serial_out  out  1      serial data bit, registered
//  bit_valid   out  1      1-cycle strobe on first cycle of each bit period
//  busy        out  1      high from cycle after accept until word fully sent
//  done        out  1      1-cycle pulse after the last bit period
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE, serial_out=0, bit_valid=0, busy=0, done=0,
//    counters and shift register cleared; load_ready=1 from the first cycle reset is low.
//  - States: IDLE -> SHIFT -> [PARITY] -> DONE -> IDLE.
//  - IDLE: accept on rising edge where load_valid && load_ready; capture data_in and
//    lsb_first. load_valid while not ready is ignored; no word is queued.
//  - SHIFT: first bit on serial_out the cycle after accept (latency 1). Each bit held
//    CLKS_PER_BIT cycles; bit_valid high in the first cycle of each period only
//    (CLKS_PER_BIT=1: bit_valid high every SHIFT cycle). data_in/lsb_first changes have
//    no effect mid-word. Exactly WIDTH bit periods, then next state.
//  - DONE: one cycle; done=1, busy=0, serial_out=0, bit_valid=0, load_ready=0.
//  - Word period accept-to-next-accept = WIDTH*CLKS_PER_BIT + 2 cycles (no parity).
//    load_valid held high gives back-to-back words at exactly that period.
//  - Counters: bit counter $clog2(WIDTH+1) bits, cycle counter $clog2(CLKS_PER_BIT+1)
//    bits; both wrap to 0 at end of each period/word, never overflow.
//  - Reset mid-word: aborts; next cycle IDLE, serial_out=0, no done pulse.
//  - Reset and load_valid in same cycle: reset wins, word not accepted.
// CONFIGURATION
//  PISO_PARITY_EN defined: PARITY state after last data bit for one extra bit period;
//    serial_out = even parity (XOR of the WIDTH data bits), bit_valid strobed as for data.
//    Word period becomes (WIDTH+1)*CLKS_PER_BIT + 2 cycles.
//  PISO_PARITY_EN undefined: no PARITY state, no parity logic; SHIFT goes direct to DONE.
// TESTING
//  1 reset high 3 cycles then low, load_valid=0 -> serial_out=0, busy=0, done=0,
//    load_ready=1, bit_valid=0.
//  2 WIDTH=8, CLKS_PER_BIT=1, accept 8'h1E, lsb_first=0 -> serial_out 0,0,0,1,1,1,1,0
//    in cycles 1..8, bit_valid=1 each, done=1 in cycle 9, load_ready=1 in cycle 10.
//  3 same, lsb_first=1 -> serial_out 0,1,1,1,1,0,0,0 in cycles 1..8.
//  4 CLKS_PER_BIT=4, load_valid held high, words 8'hA5 then 8'h3C -> each bit held 4
//    cycles, bit_valid once per 4 cycles, second accept exactly 34 cycles after first.
//  5 reset pulsed during 3rd bit of 8'hFF -> next cycle IDLE, serial_out=0, busy=0,
//    no done; following word 8'h81 transmits correctly.
//  6 PISO_PARITY_EN, CLKS_PER_BIT=1: 8'h07 -> 9th bit 1; 8'h03 -> 9th bit 0; done in
//    cycle 10.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// shifts it out MSB- or LSB-first. Define PISO_PARITY_EN to append an even-parity bit.
module piso_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lsb_first,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: a word is accepted on a rising edge where load_valid && load_ready;
    // load_ready is high only in IDLE, and nothing is queued while it is low.

    localparam int BW = $clog2(WIDTH + 1);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef PISO_PARITY_EN
        PARITY = 2'd2,
`endif
        DONE   = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] load_word;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [CW-1:0]    cyc_cnt, cyc_cnt_n;
    logic             accept, period_end, last_bit;
    logic             serial_d, bit_valid_d, busy_d, done_d;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    assign load_ready = (state == IDLE);
    assign state_dbg  = state;
    assign accept     = load_valid && load_ready;
    assign period_end = (cyc_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_bit   = (bit_cnt == BW'(WIDTH - 1));

    // Words are normalised to MSB-first at accept so the shifter only moves one way.
    always_comb begin
        load_word = data_in;
        if (lsb_first) begin
            for (int i = 0; i < WIDTH; i++) begin
                load_word[i] = data_in[WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            shreg      <= '0;
            serial_out <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            cyc_cnt    <= cyc_cnt_n;
            serial_out <= serial_d;
            bit_valid  <= bit_valid_d;
            busy       <= busy_d;
            done       <= done_d;
            if (accept) begin
                shreg <= load_word;
            end else if (state == SHIFT && period_end) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^data_in;
        end
    end
`endif

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        cyc_cnt_n = cyc_cnt;
        case (state)
            IDLE: begin
                if (accept) state_n = SHIFT;
            end
            SHIFT: begin
                if (period_end) begin
                    cyc_cnt_n = '0;
                    if (last_bit) begin
                        bit_cnt_n = '0;
`ifdef PISO_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = DONE;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end else begin
                    cyc_cnt_n = cyc_cnt + CW'(1);
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (period_end) begin
                    cyc_cnt_n = '0;
                    state_n   = DONE;
                end else begin
                    cyc_cnt_n = cyc_cnt + CW'(1);
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs are computed for the state being entered.
    always_comb begin
        serial_d = 1'b0;
        case (state_n)
            SHIFT: begin
                if (state == IDLE)   serial_d = load_word[WIDTH-1];
                else if (period_end) serial_d = shreg[WIDTH-2];
                else                 serial_d = serial_out;
            end
`ifdef PISO_PARITY_EN
            PARITY:  serial_d = par_q;
`endif
            default: serial_d = 1'b0;
        endcase
`ifdef PISO_PARITY_EN
        busy_d = (state_n == SHIFT) || (state_n == PARITY);
`else
        busy_d = (state_n == SHIFT);
`endif
        bit_valid_d = busy_d && (cyc_cnt_n == '0);
        done_d      = (state_n == DONE);
    end

endmodule
